// File: rtl/acc_requant_20b.sv
// acc_requant_20b
// Accumulates a configurable number of signed 20-bit partial sums into one
// dot-product value, then requantizes it to a signed OUT_W-bit result with a
// round-half-up arithmetic right shift followed by signed saturation.
//
// Ports:
//   clk_i, rst_i             - clock, asynchronous active-high reset
//   cfg_len_i, cfg_shift_i   - terms per vector (0 means 1), requant shift
//   in_valid_i/in_ready_o    - term handshake; in_sum_i, in_overflow_i payload
//   out_valid_o/out_ready_i  - result handshake; out_data_o, out_sat_o, out_err_o
//   busy_o                   - a vector is in progress or a result is held
//
// Optional feature: define ACC_REQUANT_RELU_EN to clamp negative rounded
// values to zero before saturation (the clamp does not raise out_sat_o).
module acc_requant_20b #(
  parameter int ACC_W = 32,
  parameter int LEN_W = 8,
  parameter int OUT_W = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [LEN_W-1:0]        cfg_len_i,
  input  logic [4:0]              cfg_shift_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic signed [19:0]      in_sum_i,
  input  logic                    in_overflow_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic signed [OUT_W-1:0] out_data_o,
  output logic                    out_sat_o,
  output logic                    out_err_o,
  output logic                    busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_ROUND = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  localparam logic [LEN_W-1:0]        LEN_ONE = LEN_W'(1);
  localparam logic signed [ACC_W:0]   ONE_EXT = (ACC_W+1)'(1);
  localparam logic signed [ACC_W:0]   SAT_MAX =
    $signed({{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}});
  localparam logic signed [ACC_W:0]   SAT_MIN =
    $signed({{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}});

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic signed [ACC_W-1:0]   r_acc;
  logic [LEN_W-1:0]          r_cnt;
  logic [LEN_W-1:0]          r_len;
  logic [4:0]                r_shift;
  logic                      r_err;
  logic                      r_in_ready;
  logic                      r_out_valid;
  logic                      r_busy;
  logic signed [OUT_W-1:0]   r_out_data;
  logic                      r_out_sat;
  logic                      r_out_err;

  logic                      w_accept;
  logic signed [ACC_W-1:0]   w_sum_ext;
  logic signed [ACC_W:0]     w_acc_ext;
  logic signed [ACC_W:0]     w_bias;
  logic signed [ACC_W:0]     w_round;
  logic signed [ACC_W:0]     w_clip;
  logic signed [OUT_W-1:0]   w_data;
  logic                      w_sat;

  assign w_accept  = in_valid_i & r_in_ready;
  assign w_sum_ext = {{(ACC_W-20){in_sum_i[19]}}, in_sum_i};
  assign w_acc_ext = {r_acc[ACC_W-1], r_acc};

  // Next-state logic for the accumulate / round / hold sequence.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          // Length 0 and 1 both mean a single-term vector.
          if (cfg_len_i <= LEN_ONE) begin
            w_state_nxt = ST_ROUND;
          end else begin
            w_state_nxt = ST_ACCUM;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (w_accept && ((r_cnt + LEN_ONE) == r_len)) begin
          w_state_nxt = ST_ROUND;
        end else begin
          w_state_nxt = ST_ACCUM;
        end
      end
      ST_ROUND: w_state_nxt = ST_HOLD;
      ST_HOLD: begin
        if (out_ready_i) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_HOLD;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Round-half-up shift, optional ReLU clamp, then signed saturation.
  always_comb begin
    w_bias = '0;
    if (r_shift != 5'd0) begin
      w_bias = ONE_EXT << (r_shift - 5'd1);
    end else begin
      w_bias = '0;
    end
    w_round = (w_acc_ext + w_bias) >>> r_shift;
`ifdef ACC_REQUANT_RELU_EN
    if (w_round[ACC_W]) begin
      w_clip = '0;
    end else begin
      w_clip = w_round;
    end
`else
    w_clip = w_round;
`endif
    if (w_clip > SAT_MAX) begin
      w_data = SAT_MAX[OUT_W-1:0];
      w_sat  = 1'b1;
    end else if (w_clip < SAT_MIN) begin
      w_data = SAT_MIN[OUT_W-1:0];
      w_sat  = 1'b1;
    end else begin
      w_data = w_clip[OUT_W-1:0];
      w_sat  = 1'b0;
    end
  end

  // State register plus handshake/status outputs decoded from the next state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_ACCUM);
      r_out_valid <= (w_state_nxt == ST_HOLD);
      r_busy      <= (w_state_nxt != ST_IDLE);
    end
  end

  // Accumulator, term counter, latched configuration and result registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_acc      <= '0;
      r_cnt      <= '0;
      r_len      <= '0;
      r_shift    <= 5'd0;
      r_err      <= 1'b0;
      r_out_data <= '0;
      r_out_sat  <= 1'b0;
      r_out_err  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_len   <= cfg_len_i;
            r_shift <= cfg_shift_i;
            r_acc   <= w_sum_ext;
            r_cnt   <= LEN_ONE;
            r_err   <= in_overflow_i;
          end
        end
        ST_ACCUM: begin
          if (w_accept) begin
            r_acc <= r_acc + w_sum_ext;
            r_cnt <= r_cnt + LEN_ONE;
            r_err <= r_err | in_overflow_i;
          end
        end
        ST_ROUND: begin
          r_out_data <= w_data;
          r_out_sat  <= w_sat;
          r_out_err  <= r_err;
        end
        default: begin
          r_acc <= r_acc;
        end
      endcase
    end
  end

  assign in_ready_o  = r_in_ready;
  assign out_valid_o = r_out_valid;
  assign busy_o      = r_busy;
  assign out_data_o  = r_out_data;
  assign out_sat_o   = r_out_sat;
  assign out_err_o   = r_out_err;

endmodule

// File: tb/tb_acc_requant_20b.sv
// Directed-vector bench for acc_requant_20b. Stimulus pushes the hand-computed
// result of each vector into a queue; a monitor pops and compares on every
// output handshake.
module tb_acc_requant_20b;

  logic              clk_i;
  logic              rst_i;
  logic [7:0]        cfg_len_i;
  logic [4:0]        cfg_shift_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic signed [19:0] in_sum_i;
  logic              in_overflow_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic signed [7:0] out_data_o;
  logic              out_sat_o;
  logic              out_err_o;
  logic              busy_o;

  typedef struct {
    int data;
    bit sat;
    bit err;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  acc_requant_20b #(.ACC_W(32), .LEN_W(8), .OUT_W(8)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .cfg_len_i    (cfg_len_i),
    .cfg_shift_i  (cfg_shift_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .in_sum_i     (in_sum_i),
    .in_overflow_i(in_overflow_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_data_o   (out_data_o),
    .out_sat_o    (out_sat_o),
    .out_err_o    (out_err_o),
    .busy_o       (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0d req=%0d", name, act, exp);
    end
  endtask

  // Expected values are written as the plain signed-saturation result; the
  // ReLU build turns any negative result into 0 without saturation.
  task automatic push_exp(input int data, input bit sat, input bit err);
    exp_t e;
    e.data = data;
    e.sat  = sat;
    e.err  = err;
`ifdef ACC_REQUANT_RELU_EN
    if (e.data < 0) begin
      e.data = 0;
      e.sat  = 1'b0;
    end
`endif
    q.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send_term(input logic signed [19:0] s, input logic ovf);
    int b;
    b = 0;
    in_valid_i    = 1'b1;
    in_sum_i      = s;
    in_overflow_i = ovf;
    while (!in_ready_o && b < 50) begin
      @(posedge clk_i); #1;
      b++;
    end
    if (!in_ready_o) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout act=%0d req=1", in_ready_o);
    end
    @(posedge clk_i); #1;
    in_valid_i    = 1'b0;
    in_overflow_i = 1'b0;
  endtask

  task automatic one(input logic [7:0] len, input logic [4:0] sh,
                     input logic signed [19:0] t, input int d, input bit s);
    cfg_len_i   = len;
    cfg_shift_i = sh;
    push_exp(d, s, 1'b0);
    send_term(t, 1'b0);
  endtask

  task automatic wait_drain();
    int b;
    b = 0;
    while (q.size() != 0 && b < 200) begin
      @(posedge clk_i); #1;
      b++;
    end
    check("drain", q.size(), 0);
    repeat (2) @(posedge clk_i);
    #1;
  endtask

  // Scoreboard monitor: compare at every output handshake.
  always @(negedge clk_i) begin
    if (!rst_i && out_valid_o && out_ready_i) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_output act=%0d req=none", out_data_o);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("out_data", out_data_o, e.data);
        check("out_sat", {31'd0, out_sat_o}, {31'd0, e.sat});
        check("out_err", {31'd0, out_err_o}, {31'd0, e.err});
      end
    end
  end

  initial begin
    rst_i         = 1'b1;
    cfg_len_i     = 8'd0;
    cfg_shift_i   = 5'd0;
    in_valid_i    = 1'b0;
    in_sum_i      = 20'sd0;
    in_overflow_i = 1'b0;
    out_ready_i   = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_in_ready", in_ready_o, 1);
    check("rst_out_valid", out_valid_o, 0);
    check("rst_out_data", out_data_o, 0);
    check("rst_out_sat", out_sat_o, 0);
    check("rst_out_err", out_err_o, 0);
    check("rst_busy", busy_o, 0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    // Basic accumulate; config changes after the first term are ignored.
    cfg_len_i   = 8'd4;
    cfg_shift_i = 5'd0;
    push_exp(100, 1'b0, 1'b0);
    send_term(20'sd10, 1'b0);
    cfg_len_i   = 8'd1;
    cfg_shift_i = 5'd3;
    send_term(20'sd20, 1'b0);
    send_term(20'sd30, 1'b0);
    send_term(20'sd40, 1'b0);
    check("lat_round_valid", out_valid_o, 0);
    check("lat_round_ready", in_ready_o, 0);
    check("lat_round_busy", busy_o, 1);
    @(posedge clk_i); #1;
    check("lat_hold_valid", out_valid_o, 1);
    wait_drain();

    // Rounding, half-up.
    cfg_len_i = 8'd2; cfg_shift_i = 5'd2;
    push_exp(2, 1'b0, 1'b0);
    send_term(20'sd5, 1'b0);
    send_term(20'sd2, 1'b0);
    push_exp(-2, 1'b0, 1'b0);
    send_term(-20'sd5, 1'b0);
    send_term(-20'sd2, 1'b0);
    one(8'd1, 5'd4, 20'sd8, 1, 1'b0);
    one(8'd1, 5'd4, -20'sd8, 0, 1'b0);
    one(8'd1, 5'd4, -20'sd9, -1, 1'b0);
    one(8'd1, 5'd31, -20'sd524288, 0, 1'b0);

    // Saturation and length 0.
    one(8'd1, 5'd0, 20'sd524287, 127, 1'b1);
    one(8'd1, 5'd0, -20'sd524288, -128, 1'b1);
    one(8'd0, 5'd0, 20'sd524287, 127, 1'b1);
    one(8'd0, 5'd0, -20'sd524288, -128, 1'b1);
    one(8'd1, 5'd12, 20'sd524287, 127, 1'b1);
    wait_drain();

    // Backpressure with an overflow flag on the second term only.
    out_ready_i = 1'b0;
    cfg_len_i = 8'd3; cfg_shift_i = 5'd0;
    push_exp(6, 1'b0, 1'b1);
    send_term(20'sd1, 1'b0);
    send_term(20'sd2, 1'b1);
    send_term(20'sd3, 1'b0);
    @(posedge clk_i); #1;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", out_valid_o, 1);
      check("bp_in_ready", in_ready_o, 0);
      check("bp_data", out_data_o, 6);
      check("bp_err", out_err_o, 1);
      @(posedge clk_i); #1;
    end
    out_ready_i = 1'b1;
    @(posedge clk_i); #1;
    check("bp_release_valid", out_valid_o, 0);
    check("bp_release_busy", busy_o, 0);
    check("bp_release_ready", in_ready_o, 1);
    wait_drain();

    // Reset mid-vector discards the partial result.
    cfg_len_i = 8'd8; cfg_shift_i = 5'd0;
    send_term(20'sd100, 1'b1);
    send_term(20'sd100, 1'b0);
    send_term(20'sd100, 1'b0);
    rst_i = 1'b1;
    #1;
    check("mid_rst_busy", busy_o, 0);
    check("mid_rst_ready", in_ready_o, 1);
    check("mid_rst_valid", out_valid_o, 0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    cfg_len_i = 8'd2;
    push_exp(2, 1'b0, 1'b0);
    send_term(20'sd1, 1'b0);
    send_term(20'sd1, 1'b0);

    // ReLU configuration check.
    one(8'd1, 5'd0, -20'sd100, -100, 1'b0);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
